// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: command encoding,
// FSM state encoding, bus widths and the RAM-region address decode.
package mem_arbiter_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int RAM_AW = 8;

   // mem_cmd encoding; 2'b11 is reserved and behaves like NONE
   localparam logic [1:0] NONE   = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   // RAM occupies the lower half of the 9-bit word space
   localparam int   RAM_SEL_BIT = 8;
   localparam logic RAM_SEL_VAL = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic cmd_valid(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction

   function automatic logic is_ram_addr(input logic [ADDR_W-1:0] addr);
      return addr[RAM_SEL_BIT] == RAM_SEL_VAL;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input grant logic. Round-robin on ties by default; with
// MEM_ARB_FIXED_PRIO_EN defined, requester 0 always wins a tie and no
// last-grant history is kept.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic gnt_valid,
   output logic gnt_idx
);

`ifdef MEM_ARB_FIXED_PRIO_EN

   // Fixed priority: requester 1 only wins when requester 0 is idle
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_idx   = req1 & ~req0;
   end

`else

   logic last_grant_q;
   logic last_grant_d;

   // Grant decision: single requester wins, a tie goes to the one not granted last
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_idx   = req1 & ~req0;
      if (req0 && req1) begin
         gnt_idx = ~last_grant_q;
      end
      last_grant_d = last_grant_q;
      if (take && gnt_valid) begin
         last_grant_d = gnt_idx;
      end
   end

   // Grant history; resets to 1 so requester 0 takes the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU (r0) and loader/DMA (r1) onto the single-port 256x16 RAM.
// Out-of-range addresses (addr[8]==1) complete with err and never touch the RAM.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (r0 wins ties)
// instead of round-robin; see rr_arbiter2.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        r0_cmd,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic              r0_err,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic [1:0]        r1_cmd,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic              r1_err,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   state_e            state_q, state_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [RAM_AW-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              gidx_q, gidx_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              gnt_valid;
   logic              gnt_idx;
   logic [1:0]        sel_cmd;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req0      (cmd_valid(r0_cmd)),
      .req1      (cmd_valid(r1_cmd)),
      .take      (state_q == ST_IDLE),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Winner's request fields
   always_comb begin
      sel_cmd   = gnt_idx ? r1_cmd   : r0_cmd;
      sel_addr  = gnt_idx ? r1_addr  : r0_addr;
      sel_wdata = gnt_idx ? r1_wdata : r0_wdata;
   end

   // Next-state and latch-register update
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      gidx_d  = gidx_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               cmd_d   = sel_cmd;
               addr_d  = sel_addr[RAM_AW-1:0];
               wdata_d = sel_wdata;
               gidx_d  = gnt_idx;
               // cleared here so writes and errors complete with zero rdata
               rdata_d = '0;
               if (is_ram_addr(sel_addr)) begin
                  err_d   = 1'b0;
                  state_d = ST_SERVE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_SERVE: begin
            state_d = (cmd_q == MWRITE) ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            rdata_d = ram_dout;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latch registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cmd_q   <= NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         gidx_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         gidx_q  <= gidx_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode from state so an async reset drops them at once
   always_comb begin
      ram_addr  = '0;
      ram_write = 1'b0;
      ram_din   = '0;
      r0_ack    = 1'b0;
      r0_err    = 1'b0;
      r0_rdata  = '0;
      r1_ack    = 1'b0;
      r1_err    = 1'b0;
      r1_rdata  = '0;
      busy      = (state_q != ST_IDLE);
      if (state_q == ST_SERVE) begin
         ram_addr  = addr_q;
         ram_write = (cmd_q == MWRITE);
         ram_din   = wdata_q;
      end
      if (state_q == ST_DONE) begin
         if (gidx_q) begin
            r1_ack   = 1'b1;
            r1_err   = err_q;
            r1_rdata = rdata_q;
         end else begin
            r0_ack   = 1'b1;
            r0_err   = err_q;
            r0_rdata = rdata_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

   localparam logic [1:0] C_NONE   = 2'b00;
   localparam logic [1:0] C_MREAD  = 2'b01;
   localparam logic [1:0] C_MWRITE = 2'b10;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  r0_cmd, r1_cmd;
   logic [8:0]  r0_addr, r1_addr;
   logic [15:0] r0_wdata, r1_wdata;
   logic        r0_ack, r0_err, r1_ack, r1_err;
   logic [15:0] r0_rdata, r1_rdata;
   logic [7:0]  ram_addr;
   logic        ram_write;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;
   logic        busy;

   logic [15:0] mem [256];

   typedef struct {
      int          idx;
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .r0_cmd    (r0_cmd),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_ack    (r0_ack),
      .r0_err    (r0_err),
      .r0_rdata  (r0_rdata),
      .r1_cmd    (r1_cmd),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_ack    (r1_ack),
      .r1_err    (r1_err),
      .r1_rdata  (r1_rdata),
      .ram_addr  (ram_addr),
      .ram_write (ram_write),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, read-before-write
   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: every completion pops the next expected response
   always @(negedge clk) begin
      if (!reset && (r0_ack || r1_ack)) begin
         chk("ack_exclusive", {31'd0, r0_ack & r1_ack}, 32'd0);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: r0_ack=%0b r1_ack=%0b, expected no completion", r0_ack, r1_ack);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("ack_idx",   r1_ack ? 32'd1 : 32'd0, e.idx);
            chk("ack_err",   {31'd0, r1_ack ? r1_err : r0_err}, {31'd0, e.err});
            chk("ack_rdata", {16'd0, r1_ack ? r1_rdata : r0_rdata}, {16'd0, e.rdata});
         end
      end
   end

   task automatic pulse_reset();
      @(negedge clk);
      reset  = 1'b1;
      r0_cmd = C_NONE;
      r1_cmd = C_NONE;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Single request from one requester; measures ack latency and busy cycles
   task automatic do_req(input int r, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] wd, input logic e_err, input logic [15:0] e_rd,
                         input int e_lat, input string tag);
      int          lat;
      int          bcnt;
      logic        anyram;
      logic        oth;
      logic        w1;
      logic [7:0]  a1;
      logic [15:0] d1;
      exp_t        e;
      e.idx = r; e.err = e_err; e.rdata = e_rd;
      sb_q.push_back(e);
      @(posedge clk); #1;
      if (r == 0) begin r0_cmd = cmd; r0_addr = addr; r0_wdata = wd; end
      else        begin r1_cmd = cmd; r1_addr = addr; r1_wdata = wd; end
      lat = -1; bcnt = 0; anyram = 1'b0; oth = 1'b0;
      w1 = 1'b0; a1 = '0; d1 = '0;
      for (int k = 0; k < 12 && lat < 0; k++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (ram_write || ram_addr != 8'd0) anyram = 1'b1;
         if (k == 1) begin w1 = ram_write; a1 = ram_addr; d1 = ram_din; end
         if (r == 0 ? r1_ack : r0_ack) oth = 1'b1;
         if (r == 0 ? r0_ack : r1_ack) lat = k;
      end
      chk({tag, "_latency"}, lat, e_lat);
      chk({tag, "_busy_cycles"}, bcnt, e_lat);
      chk({tag, "_other_ack"}, {31'd0, oth}, 32'd0);
      if (cmd == C_MWRITE && !e_err) begin
         chk({tag, "_ram_write"}, {31'd0, w1}, 32'd1);
         chk({tag, "_ram_addr"}, {24'd0, a1}, {24'd0, addr[7:0]});
         chk({tag, "_ram_din"}, {16'd0, d1}, {16'd0, wd});
      end
      if (e_err) chk({tag, "_ram_untouched"}, {31'd0, anyram}, 32'd0);
      @(posedge clk); #1;
      if (r == 0) r0_cmd = C_NONE; else r1_cmd = C_NONE;
   endtask

   // Both requesters at once; r0 may reissue once on the edge ending its DONE
   task automatic dual(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] d0,
                       input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] d1,
                       input logic re, input logic [1:0] c0b, input logic [8:0] a0b,
                       input logic [15:0] d0b, input string tag);
      logic k0, k1, reissued;
      int   n;
      @(posedge clk); #1;
      r0_cmd = c0; r0_addr = a0; r0_wdata = d0;
      r1_cmd = c1; r1_addr = a1; r1_wdata = d1;
      reissued = 1'b0;
      n = 0;
      while (!(r0_cmd == C_NONE && r1_cmd == C_NONE) && n < 60) begin
         @(negedge clk);
         k0 = r0_ack; k1 = r1_ack;
         @(posedge clk); #1;
         if (k0) begin
            if (re && !reissued) begin
               r0_cmd = c0b; r0_addr = a0b; r0_wdata = d0b; reissued = 1'b1;
            end else begin
               r0_cmd = C_NONE;
            end
         end
         if (k1) r1_cmd = C_NONE;
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: requests still pending after %0d cycles, required completion", tag, n);
         r0_cmd = C_NONE; r1_cmd = C_NONE;
      end
   endtask

   task automatic push_exp(input int idx, input logic err, input logic [15:0] rd);
      exp_t e;
      e.idx = idx; e.err = err; e.rdata = rd;
      sb_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h05] = 16'h1234;
      mem[8'h01] = 16'hABCD;
      reset = 1'b1;
      r0_cmd = C_NONE; r0_addr = '0; r0_wdata = '0;
      r1_cmd = C_NONE; r1_addr = '0; r1_wdata = '0;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
      chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
      chk("rst_acks", {30'd0, r0_ack, r1_ack}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      do_req(0, C_MWRITE, 9'h012, 16'hBEEF, 1'b0, 16'h0000, 2, "w012");
      chk("mem_12", {16'd0, mem[8'h12]}, 32'h0000BEEF);
      do_req(1, C_MREAD, 9'h005, 16'h0000, 1'b0, 16'h1234, 3, "r005");
      do_req(0, C_MREAD, 9'h012, 16'h0000, 1'b0, 16'hBEEF, 3, "r012");
      do_req(1, C_MREAD, 9'h140, 16'h0000, 1'b1, 16'h0000, 1, "r140");
      do_req(0, C_MWRITE, 9'h100, 16'hDEAD, 1'b1, 16'h0000, 1, "w100");

      // Simultaneous requests straight after reset; r0 reissues right away
      pulse_reset();
      push_exp(0, 1'b0, 16'hABCD);
`ifdef MEM_ARB_FIXED_PRIO_EN
      push_exp(0, 1'b0, 16'h0000);
      push_exp(1, 1'b0, 16'h0000);
`else
      push_exp(1, 1'b0, 16'h0000);
      push_exp(0, 1'b0, 16'h0000);
`endif
      dual(C_MREAD, 9'h001, 16'h0000, C_MWRITE, 9'h002, 16'h5555,
           1'b1, C_MWRITE, 9'h003, 16'h7777, "tie");
      chk("mem_02", {16'd0, mem[8'h02]}, 32'h00005555);
      chk("mem_03", {16'd0, mem[8'h03]}, 32'h00007777);
      chk("tie_drained", sb_q.size(), 0);

      // Reset during SERVE of a write
      @(posedge clk); #1;
      r0_cmd = C_MWRITE; r0_addr = 9'h020; r0_wdata = 16'h9999;
      @(posedge clk); #2;
      chk("serve_busy", {31'd0, busy}, 32'd1);
      chk("serve_ram_write", {31'd0, ram_write}, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_ram_write", {31'd0, ram_write}, 32'd0);
      chk("abort_ram_addr", {24'd0, ram_addr}, 32'd0);
      chk("abort_ram_din", {16'd0, ram_din}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_acks", {30'd0, r0_ack, r1_ack}, 32'd0);
      r0_cmd = C_NONE;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);

      push_exp(0, 1'b0, 16'hABCD);
      push_exp(1, 1'b0, 16'h1234);
      dual(C_MREAD, 9'h001, 16'h0000, C_MREAD, 9'h005, 16'h0000,
           1'b0, C_NONE, 9'h000, 16'h0000, "post_rst_tie");

      // Reserved command is not a request
      @(posedge clk); #1;
      r0_cmd = 2'b11; r0_addr = 9'h004;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("cmd11_busy", {31'd0, busy}, 32'd0);
      end
      @(posedge clk); #1;
      r0_cmd = C_NONE;

      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
